// File: rtl/mem_load_ctrl_pkg.sv
// Shared definitions for the frame-to-memory loader and the memory it feeds:
// FSM encoding, header byte layout and memory geometry.
package mem_load_ctrl_pkg;

    localparam int DEPTH  = 320;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 9;

    // Header byte 0 carries addr[8] in this bit; every other bit must be zero.
    localparam int HDR_HI_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_LEN,
        ST_DATA,
        ST_DRAIN
    } state_t;

    function automatic logic hdr_hi_bad(input logic [7:0] b);
        return |b[7:1];
    endfunction

endpackage

// File: rtl/mem_load_ctrl.sv
// Parses addr_hi/addr_lo/len headed byte frames into memory writes, one cycle after each data byte.
// Never back-pressures: in_ready drops only under reset or abort.
module mem_load_ctrl
    import mem_load_ctrl_pkg::*;
#(
    parameter int M  = DEPTH,
    parameter int N  = 8,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          clear_err
);

    state_t             r_state, w_state;
    logic [AW-1:0]      r_addr, w_addr;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_addr_hi, w_addr_hi;
    logic               r_bad, w_bad;
    logic               r_err, w_err;
    logic [AW-1:0]      r_mem_addr, w_mem_addr;
    logic [N-1:0]       r_mem_data, w_mem_data;
    logic               r_mem_we, w_mem_we;
    logic               r_done, w_done;

    logic               w_err_ev;
    logic [8:0]         w_start;
    logic               w_oob;

    assign w_start = {r_addr_hi, in_data};
    assign w_oob   = (32'(w_start) >= 32'(M));

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_cnt      = r_cnt;
        w_addr_hi  = r_addr_hi;
        w_bad      = r_bad;
        w_err_ev   = 1'b0;
        w_mem_addr = r_mem_addr;
        w_mem_data = r_mem_data;
        w_mem_we   = 1'b0;
        w_done     = 1'b0;

        if (abort) begin
            w_state = ST_IDLE;
        end else if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_addr_hi = in_data[HDR_HI_BIT];
                    w_bad     = hdr_hi_bad(in_data);
                    w_err_ev  = w_bad;
                    w_state   = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    w_addr   = AW'(w_start);
                    w_bad    = r_bad | w_oob;
                    w_err_ev = w_oob;
                    w_state  = ST_LEN;
                end
                ST_LEN: begin
                    w_cnt   = {1'b0, in_data} + 9'd1;
                    w_state = r_bad ? ST_DRAIN : ST_DATA;
                end
                ST_DATA: begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_addr;
                    w_mem_data = N'(in_data);
                    w_addr     = (r_addr == AW'(M - 1)) ? '0 : r_addr + AW'(1);
                    w_cnt      = r_cnt - 9'd1;
                    if (r_cnt == 9'd1) begin
                        w_done  = 1'b1;
                        w_state = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    w_cnt = r_cnt - 9'd1;
                    if (r_cnt == 9'd1) begin
                        w_state = ST_IDLE;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end

        // A new error outranks a simultaneous clear.
        w_err = w_err_ev | (r_err & ~clear_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_addr_hi  <= 1'b0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_cnt      <= w_cnt;
            r_addr_hi  <= w_addr_hi;
            r_bad      <= w_bad;
            r_err      <= w_err;
            r_mem_addr <= w_mem_addr;
            r_mem_data <= w_mem_data;
            r_mem_we   <= w_mem_we;
            r_done     <= w_done;
        end
    end

    assign in_ready = rst_n & ~abort;
    assign busy     = (r_state != ST_IDLE);
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Bench for mem_load_ctrl: frame-level reference model checked every cycle, plus directed frames.
module tb_mem_load_ctrl;

    localparam int M  = 320;
    localparam int N  = 8;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          abort = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          err;
    logic          clear_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_load_ctrl #(.M(M), .N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .clear_err (clear_err)
    );

    always #5 clk = ~clk;

    // Frame model: pos counts header bytes seen, data bytes tracked by k out of total.
    typedef struct {
        int pos;
        int hi;
        int start;
        int total;
        int k;
        bit bad;
        bit err;
        bit we;
        bit done;
        int addr;
        int data;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.pos = 0; s.hi = 0; s.start = 0; s.total = 0; s.k = 0;
        s.bad = 0; s.err = 0; s.we = 0; s.done = 0; s.addr = 0; s.data = 0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input bit v, input int d,
                                      input bit ab, input bit clr);
        mdl_t n;
        bit   ev;
        n      = s;
        ev     = 0;
        n.we   = 0;
        n.done = 0;
        if (ab) begin
            n.pos = 0;
        end else if (v) begin
            if (s.pos == 0) begin
                n.hi  = d % 2;
                n.bad = (d > 1);
                ev    = n.bad;
                n.pos = 1;
            end else if (s.pos == 1) begin
                n.start = s.hi * 256 + d;
                if (n.start >= M) begin
                    ev    = 1;
                    n.bad = 1;
                end
                n.pos = 2;
            end else if (s.pos == 2) begin
                n.total = d + 1;
                n.k     = 0;
                n.pos   = 3;
            end else begin
                if (!s.bad) begin
                    n.we   = 1;
                    n.addr = (s.start + s.k) % M;
                    n.data = d;
                end
                n.k = s.k + 1;
                if (n.k == s.total) begin
                    n.pos  = 0;
                    n.done = !s.bad;
                end
            end
        end
        if (ev) n.err = 1;
        else if (clr) n.err = 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= mdl_step(m, in_valid, int'(in_data), abort, clear_err);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(rst_n && !abort));
        chk("busy",     int'(busy),     int'(m.pos != 0));
        chk("mem_we",   int'(mem_we),   int'(m.we));
        chk("done",     int'(done),     int'(m.done));
        chk("err",      int'(err),      int'(m.err));
        chk("mem_addr", int'(mem_addr), m.addr);
        chk("mem_data", int'(mem_data), m.data);
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string nm, input int a, input int d, input int dn);
        chk({nm, " we"},   int'(mem_we),   1);
        chk({nm, " addr"}, int'(mem_addr), a);
        chk({nm, " data"}, int'(mem_data), d);
        chk({nm, " done"}, int'(done),     dn);
    endtask

    byte unsigned q[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_we", int'(mem_we), 0);
        chk("rst mem_addr", int'(mem_addr), 0);
        chk("rst mem_data", int'(mem_data), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        chk("rst in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        idle(2);

        // Plain four-byte frame at address 16
        send(8'h00); send(8'h10); send(8'h03);
        send(8'hAA); expect_wr("f1 b0", 16, 'hAA, 0);
        send(8'hBB); expect_wr("f1 b1", 17, 'hBB, 0);
        send(8'hCC); expect_wr("f1 b2", 18, 'hCC, 0);
        send(8'hDD); expect_wr("f1 b3", 19, 'hDD, 1);
        idle(1);
        chk("f1 we after", int'(mem_we), 0);
        chk("f1 addr hold", int'(mem_addr), 19);
        chk("f1 busy", int'(busy), 0);
        chk("f1 err", int'(err), 0);

        // Address wrap from M-1 to 0
        send(8'h01); send(8'h3E); send(8'h02);
        send(8'h11); expect_wr("f2 b0", 318, 'h11, 0);
        send(8'h22); expect_wr("f2 b1", 319, 'h22, 0);
        send(8'h33); expect_wr("f2 b2", 0,   'h33, 1);
        idle(1);
        chk("f2 err", int'(err), 0);

        // Start address == M drains the frame
        send(8'h01); send(8'h40);
        chk("f3 err set", int'(err), 1);
        send(8'h01);
        send(8'h55); chk("f3 no we0", int'(mem_we), 0);
        send(8'h66); chk("f3 no we1", int'(mem_we), 0);
        chk("f3 no done", int'(done), 0);
        chk("f3 busy", int'(busy), 0);
        send(8'h00); send(8'h00); send(8'h00);
        send(8'h77); expect_wr("f4", 0, 'h77, 1);
        chk("f4 err sticky", int'(err), 1);
        in_valid = 1'b0; clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        chk("clear err", int'(err), 0);

        // Abort mid-frame with a concurrent byte
        send(8'h00); send(8'h05); send(8'h04);
        send(8'hA1); expect_wr("f5 b0", 5, 'hA1, 0);
        send(8'hA2); expect_wr("f5 b1", 6, 'hA2, 0);
        in_valid = 1'b1; in_data = 8'hA3; abort = 1'b1;
        #1;
        chk("abort in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort we", int'(mem_we), 0);
        chk("abort done", int'(done), 0);
        chk("abort busy", int'(busy), 0);
        send(8'h00); send(8'h08); send(8'h00);
        send(8'h5A); expect_wr("f6", 8, 'h5A, 1);
        idle(1);

        // Reset while the second write of a frame is on the bus
        send(8'h00); send(8'h20); send(8'h03);
        send(8'hB0); expect_wr("f7 b0", 32, 'hB0, 0);
        send(8'hB1); expect_wr("f7 b1", 33, 'hB1, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst we", int'(mem_we), 0);
        chk("arst addr", int'(mem_addr), 0);
        chk("arst data", int'(mem_data), 0);
        chk("arst busy", int'(busy), 0);
        chk("arst in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        clear_err = 1'b1;
        send(8'h02);
        clear_err = 1'b0;
        chk("set beats clear", int'(err), 1);
        chk("bad hdr busy", int'(busy), 1);
        in_valid = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort keeps err", int'(err), 1);
        idle(2);

        // Randomized frames with gaps, aborts and clears
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (q.size() == 0) begin
                int hi, lo, len;
                hi  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 1);
                lo  = (hi == 1) ? $urandom_range(0, 79) : $urandom_range(0, 255);
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
                q.push_back(8'(hi));
                q.push_back(8'(lo));
                q.push_back(8'(len));
                for (int i = 0; i <= len; i++) q.push_back(8'($urandom_range(0, 255)));
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = in_valid ? q[0] : 8'($urandom_range(0, 255));
            abort     = ($urandom_range(0, 59) == 0);
            clear_err = ($urandom_range(0, 29) == 0);
            @(posedge clk);
            if (in_valid && !abort) void'(q.pop_front());
            #1;
        end
        in_valid = 1'b0; abort = 1'b0; clear_err = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
